// File: rtl/multicycle_control_unit_pkg.sv
// multicycle_control_unit_pkg: states, opcode/Funct codes, ULA codes and per-state control decode (package mc_pkg)
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd15
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_NOR = 3'b011;
  localparam logic [2:0] ULA_SLT = 3'b111;
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       ula_src_a;
    logic [1:0] ula_src_b;
    logic [1:0] pc_src;
    logic [2:0] ula_control;
    logic       halt;
  } ctrl_t;
  // exec_alu is only consulted for EXECUTE, whose ULA op comes from Funct
  function automatic ctrl_t decode(state_t s, logic [2:0] exec_alu);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.ir_write = 1'b1; c.pc_write = 1'b1; c.ula_src_b = 2'b01; c.ula_control = ULA_ADD; end
      S_DECODE:   begin c.ula_src_b = 2'b11; c.ula_control = ULA_ADD; end
      S_MEMADR:   begin c.ula_src_a = 1'b1; c.ula_src_b = 2'b10; c.ula_control = ULA_ADD; end
      S_MEMRD:    c.iord = 1'b1;
      S_MEMWB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      S_MEMWR:    begin c.iord = 1'b1; c.mem_write = 1'b1; end
      S_EXECUTE:  begin c.ula_src_a = 1'b1; c.ula_control = exec_alu; end
      S_ALUWB:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      S_BRANCH:   begin c.ula_src_a = 1'b1; c.ula_control = ULA_SUB; c.pc_src = 2'b01; c.branch = 1'b1; end
      S_ADDIEXEC: begin c.ula_src_a = 1'b1; c.ula_src_b = 2'b10; c.ula_control = ULA_ADD; end
      S_ADDIWB:   c.reg_write = 1'b1;
      S_JUMP:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
      S_ILLEGAL:  c.halt = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: instruction fields and flag in, datapath strobes/selects and debug state out
interface multicycle_control_unit_if;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ULASrcA;
  logic [1:0] ULASrcB;
  logic [1:0] PCSrc;
  logic [2:0] ULAControl;
  logic       Halt;
  logic [3:0] State;
  modport master (
    input  OP, Funct, Zero,
    output PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ULASrcA,
           ULASrcB, PCSrc, ULAControl, Halt, State
  );
  modport slave (
    output OP, Funct, Zero,
    input  PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ULASrcA,
           ULASrcB, PCSrc, ULAControl, Halt, State
  );
endinterface

// File: rtl/multicycle_control_unit_ula_decoder.sv
// ula_decoder: R-type Funct to ULAControl, with legal flag for unsupported Funct codes
module ula_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] ula_control_o,
  output logic       legal_o
);
  always_comb begin
    ula_control_o = funct_i == F_ADD ? ULA_ADD :
                    funct_i == F_SUB ? ULA_SUB :
                    funct_i == F_AND ? ULA_AND :
                    funct_i == F_OR  ? ULA_OR  :
                    funct_i == F_NOR ? ULA_NOR :
                    funct_i == F_SLT ? ULA_SLT : ULA_ADD;
    legal_o = funct_i inside {F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT};
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM controller for a multicycle MIPS-style datapath.
// Define MC_BNE_EN to add BNE support (opcode 000101 through BRANCH with inverted Zero).
module multicycle_control_unit
  import mc_pkg::*;
(
  input logic                       clk,
  input logic                       rst,
  multicycle_control_unit_if.master bus
);
  state_t     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [2:0] exec_alu;
  logic       funct_legal;
  logic       is_branch;
  logic       take_branch;
  ula_decoder u_ula_decoder (
    .funct_i      (bus.Funct),
    .ula_control_o(exec_alu),
    .legal_o      (funct_legal)
  );
`ifdef MC_BNE_EN
  logic bne_q;
  assign is_branch   = bus.OP == OP_BEQ || bus.OP == OP_BNE;
  assign take_branch = bus.Zero ^ bne_q;
`else
  assign is_branch   = bus.OP == OP_BEQ;
  assign take_branch = bus.Zero;
`endif
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE:   state_d = (bus.OP == OP_LW || bus.OP == OP_SW)   ? S_MEMADR   :
                            (bus.OP == OP_RTYPE && funct_legal)     ? S_EXECUTE  :
                            is_branch                               ? S_BRANCH   :
                            bus.OP == OP_ADDI                       ? S_ADDIEXEC :
                            bus.OP == OP_J                          ? S_JUMP     : S_ILLEGAL;
      S_MEMADR:   state_d = bus.OP == OP_SW ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
    ctrl_d = decode(state_d, exec_alu);
  end
  // outputs are registered alongside the state so they change only with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode(S_FETCH, ULA_ADD);
`ifdef MC_BNE_EN
      bne_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
`ifdef MC_BNE_EN
      bne_q   <= state_q == S_DECODE ? bus.OP == OP_BNE : bne_q;
`endif
    end
  end
  assign bus.PCEn       = ctrl_q.pc_write | (ctrl_q.branch & take_branch);
  assign bus.IorD       = ctrl_q.iord;
  assign bus.MemWrite   = ctrl_q.mem_write;
  assign bus.IRWrite    = ctrl_q.ir_write;
  assign bus.RegDst     = ctrl_q.reg_dst;
  assign bus.MemtoReg   = ctrl_q.mem_to_reg;
  assign bus.RegWrite   = ctrl_q.reg_write;
  assign bus.ULASrcA    = ctrl_q.ula_src_a;
  assign bus.ULASrcB    = ctrl_q.ula_src_b;
  assign bus.PCSrc      = ctrl_q.pc_src;
  assign bus.ULAControl = ctrl_q.ula_control;
  assign bus.Halt       = ctrl_q.halt;
  assign bus.State      = state_q;
endmodule
